fft_peak_detect: RTL and testbench
==================================

// Module: fft_peak_detect
// PURPOSE
//  Streaming back-end stage fed by the bit-reversal reorder stage: takes natural-order FFT bins
//  (re/im plus bin index), computes |X|^2 per bin, streams power out, and reports the peak bin
//  once per frame. Feeds the spectrum output / host-readout logic.
// PARAMETERS
//  width   16   signed bit width of in_re / in_im
//  N       6    log2(FFT length); frame = 2^N bins; PW = 2*width (power width, unsigned)
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  areset     in   1      asynchronous reset, active-low
//  in_valid   in   1      bin strobe (reorder stage enout)
//  in_idx     in   N      bin index of in_re/in_im (reorder stage cnt_ram_out)
//  in_re      in   width  signed real part
//  in_im      in   width  signed imaginary part
//  pwr_valid  out  1      power sample valid
//  pwr_idx    out  N      bin index of pwr_out
//  pwr_out    out  PW     re^2+im^2, unsigned
//  peak_valid out  1      one-cycle pulse: frame complete, peak_* valid (held until next pulse)
//  peak_idx   out  N      index of maximum-power bin
//  peak_pwr   out  PW     power of that bin
//  frame_err  out  1      one-cycle pulse: frame aborted (in_valid dropped mid-frame)
// BEHAVIOUR
//  - Reset (areset=0): all outputs, pipeline regs, FSM to 0 / IDLE; effective immediately, mid-frame too.
//  - Power pipe, 3 stages, no stalls: S1 register inputs; S2 signed squares re*re, im*im;
//    S3 unsigned sum -> pwr_out. pwr_valid/pwr_idx = in_valid/in_idx delayed 3 cycles.
//    PW=2*width is exact: max (-2^(w-1))^2*2 = 2^(2w-1); no saturation needed.
//  - pwr stream runs for every in_valid sample, independent of FSM (incl. out-of-frame samples).
//  - FSM on S3 outputs: IDLE, ACC, REPORT.
//    IDLE: pwr_valid & pwr_idx==0 -> load peak candidate (idx 0, pwr) -> ACC. Other samples ignored
//          (upstream emits one stale sample with idx=all-ones before bin 0; it must not count).
//    ACC: each pwr_valid: if pwr_out > cand_pwr (strict) replace candidate; ties keep lower index.
//         pwr_valid & pwr_idx==2^N-1 -> REPORT. pwr_valid=0 before last bin -> frame_err pulse, IDLE.
//         pwr_idx non-consecutive (!= prev+1) -> frame_err pulse, IDLE.
//    REPORT (1 cycle): peak_idx/peak_pwr <= candidate, peak_valid=1 -> IDLE.
//  - Latency: peak_valid asserts 4 cycles after the in_valid cycle carrying idx 2^N-1.
//  - Back-to-back frames: idx 0 arriving in REPORT cycle is NOT possible (>=1 gap from upstream);
//    if it occurs it is ignored and the frame is missed (no err).
//  - peak_idx/peak_pwr hold last reported value; not disturbed by aborted frames.
// CONFIGURATION
//  FFT_PEAK_SKIP_DC_EN defined: bin 0 excluded from peak search; IDLE->ACC on idx 0 loads
//    candidate pwr=0, idx=0 (so all-zero-AC frame reports idx 0, pwr 0). pwr stream unchanged.
//  Undefined: bin 0 competes like any other bin.
// STRUCTURE
//  fft_pkg: width/N defaults, PW localparam, FSM state encodings (IDLE/ACC/REPORT).
//  Sub-module fft_pwr_pipe: 3-stage re^2+im^2 pipeline with valid/idx sideband.
//  Top: frame FSM + peak compare/hold registers.
// TESTING
//  1. Single frame, bin 5 = (1000,0), all others 0 -> pwr_out[5]=1000000, peak_idx=5,
//     peak_pwr=1000000, peak_valid 4 cycles after idx 63 input.
//  2. Upstream-style stream: idx 63 (stale, re=30000) then 0..63 with max at bin 20 -> stale
//     sample ignored, peak_idx=20.
//  3. Tie: bins 7 and 40 both (-300,400) -> peak_idx=7, peak_pwr=250000.
//  4. Extremes: re=im=-32768 at bin 1 -> pwr_out=0x8000_0000, peak_idx=1.
//  5. in_valid drops after idx 30 -> frame_err pulse, no peak_valid, peak_* unchanged;
//     next full frame reports correctly. Reset asserted at idx 40 -> all outputs 0 immediately.
//  6. Bin 0 = (5000,0), bin 9 = (10,0): without FFT_PEAK_SKIP_DC_EN peak_idx=0;
//     with it peak_idx=9, peak_pwr=100.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared defaults and FSM encoding for the FFT power / peak back-end.
// Bin width, log2 frame length and power width live here.
package fft_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int N_DEF     = 6;
    localparam int PW_DEF    = 2 * WIDTH_DEF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC    = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/fft_pwr_pipe.sv
// Three-stage re^2+im^2 pipeline with valid/index sideband.
// No stalls; every sample flows through in exactly three cycles.
module fft_pwr_pipe
    import fft_pkg::*;
#(
    parameter  int width = WIDTH_DEF,
    parameter  int N     = N_DEF,
    localparam int PW    = 2 * width
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    in_valid,
    input  logic [N-1:0]            in_idx,
    input  logic signed [width-1:0] in_re,
    input  logic signed [width-1:0] in_im,
    output logic                    pwr_valid,
    output logic [N-1:0]            pwr_idx,
    output logic [PW-1:0]           pwr_out
);

    logic                    r_s1_v;
    logic [N-1:0]            r_s1_idx;
    logic signed [width-1:0] r_s1_re;
    logic signed [width-1:0] r_s1_im;

    logic                    r_s2_v;
    logic [N-1:0]            r_s2_idx;
    logic signed [PW-1:0]    r_s2_re2;
    logic signed [PW-1:0]    r_s2_im2;

    logic                    r_s3_v;
    logic [N-1:0]            r_s3_idx;
    logic [PW-1:0]           r_s3_pwr;

    logic [PW-1:0]           w_sum;

    // Sum of two squares is at most 2^(PW-1), so PW bits never overflow.
    assign w_sum = $unsigned(r_s2_re2) + $unsigned(r_s2_im2);

    // S1 capture, S2 signed squares, S3 unsigned sum.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_s1_v   <= 1'b0;
            r_s1_idx <= '0;
            r_s1_re  <= '0;
            r_s1_im  <= '0;
            r_s2_v   <= 1'b0;
            r_s2_idx <= '0;
            r_s2_re2 <= '0;
            r_s2_im2 <= '0;
            r_s3_v   <= 1'b0;
            r_s3_idx <= '0;
            r_s3_pwr <= '0;
        end else begin
            r_s1_v   <= in_valid;
            r_s1_idx <= in_idx;
            r_s1_re  <= in_re;
            r_s1_im  <= in_im;
            r_s2_v   <= r_s1_v;
            r_s2_idx <= r_s1_idx;
            r_s2_re2 <= r_s1_re * r_s1_re;
            r_s2_im2 <= r_s1_im * r_s1_im;
            r_s3_v   <= r_s2_v;
            r_s3_idx <= r_s2_idx;
            r_s3_pwr <= w_sum;
        end
    end

    assign pwr_valid = r_s3_v;
    assign pwr_idx   = r_s3_idx;
    assign pwr_out   = r_s3_pwr;

endmodule

// File: rtl/fft_peak_detect.sv
// Per-bin power stream plus once-per-frame peak bin report.
// Build option FFT_PEAK_SKIP_DC_EN: bin 0 is excluded from the peak search.
module fft_peak_detect
    import fft_pkg::*;
#(
    parameter  int width = WIDTH_DEF,
    parameter  int N     = N_DEF,
    localparam int PW    = 2 * width
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    in_valid,
    input  logic [N-1:0]            in_idx,
    input  logic signed [width-1:0] in_re,
    input  logic signed [width-1:0] in_im,
    output logic                    pwr_valid,
    output logic [N-1:0]            pwr_idx,
    output logic [PW-1:0]           pwr_out,
    output logic                    peak_valid,
    output logic [N-1:0]            peak_idx,
    output logic [PW-1:0]           peak_pwr,
    output logic                    frame_err
);

    localparam logic [N-1:0] LAST_IDX = '1;

    logic           w_pv;
    logic [N-1:0]   w_pidx;
    logic [PW-1:0]  w_pwr;
    logic [PW-1:0]  w_first_pwr;
    logic [N-1:0]   w_next_idx;
    logic           w_better;

    state_t         r_state;
    logic [N-1:0]   r_prev_idx;
    logic [N-1:0]   r_cand_idx;
    logic [PW-1:0]  r_cand_pwr;
    logic           r_peak_valid;
    logic [N-1:0]   r_peak_idx;
    logic [PW-1:0]  r_peak_pwr;
    logic           r_frame_err;

    fft_pwr_pipe #(
        .width (width),
        .N     (N)
    ) u_pwr (
        .clk       (clk),
        .areset    (areset),
        .in_valid  (in_valid),
        .in_idx    (in_idx),
        .in_re     (in_re),
        .in_im     (in_im),
        .pwr_valid (w_pv),
        .pwr_idx   (w_pidx),
        .pwr_out   (w_pwr)
    );

`ifdef FFT_PEAK_SKIP_DC_EN
    // DC bin seeds the search at zero so any AC energy beats it.
    assign w_first_pwr = '0;
`else
    assign w_first_pwr = w_pwr;
`endif

    assign w_next_idx = r_prev_idx + N'(1);
    assign w_better   = (w_pwr > r_cand_pwr);

    // Frame tracking FSM with peak candidate and held report registers.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_state      <= ST_IDLE;
            r_prev_idx   <= '0;
            r_cand_idx   <= '0;
            r_cand_pwr   <= '0;
            r_peak_valid <= 1'b0;
            r_peak_idx   <= '0;
            r_peak_pwr   <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_peak_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_pv && w_pidx == '0) begin
                        r_cand_idx <= '0;
                        r_cand_pwr <= w_first_pwr;
                        r_prev_idx <= '0;
                        r_state    <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (!w_pv || w_pidx != w_next_idx) begin
                        r_frame_err <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_prev_idx <= w_pidx;
                        if (w_better) begin
                            r_cand_idx <= w_pidx;
                            r_cand_pwr <= w_pwr;
                        end
                        if (w_pidx == LAST_IDX) begin
                            r_peak_idx   <= w_better ? w_pidx : r_cand_idx;
                            r_peak_pwr   <= w_better ? w_pwr : r_cand_pwr;
                            r_peak_valid <= 1'b1;
                            r_state      <= ST_REPORT;
                        end
                    end
                end
                ST_REPORT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pwr_valid  = w_pv;
    assign pwr_idx    = w_pidx;
    assign pwr_out    = w_pwr;
    assign peak_valid = r_peak_valid;
    assign peak_idx   = r_peak_idx;
    assign peak_pwr   = r_peak_pwr;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect with a frame-level reference model.
// Honours FFT_PEAK_SKIP_DC_EN the same way the design does.
module tb_fft_peak_detect;

    localparam int W    = 16;
    localparam int N    = 6;
    localparam int PW   = 2 * W;
    localparam int NB   = 64;
    localparam int MAXC = 4096;

    logic                clk = 1'b0;
    logic                areset = 1'b0;
    logic                in_valid = 1'b0;
    logic [N-1:0]        in_idx = '0;
    logic signed [W-1:0] in_re = '0;
    logic signed [W-1:0] in_im = '0;
    logic                pwr_valid;
    logic [N-1:0]        pwr_idx;
    logic [PW-1:0]       pwr_out;
    logic                peak_valid;
    logic [N-1:0]        peak_idx;
    logic [PW-1:0]       peak_pwr;
    logic                frame_err;

    fft_peak_detect #(.width(W), .N(N)) dut (
        .clk        (clk),
        .areset     (areset),
        .in_valid   (in_valid),
        .in_idx     (in_idx),
        .in_re      (in_re),
        .in_im      (in_im),
        .pwr_valid  (pwr_valid),
        .pwr_idx    (pwr_idx),
        .pwr_out    (pwr_out),
        .peak_valid (peak_valid),
        .peak_idx   (peak_idx),
        .peak_pwr   (peak_pwr),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    bit rst_active = 1'b1;

    // Expected outputs indexed by the cycle interval they must appear in.
    bit     exp_pv [MAXC];
    int     exp_pi [MAXC];
    longint exp_pp [MAXC];
    bit     exp_pk [MAXC];
    int     exp_ki [MAXC];
    longint exp_kp [MAXC];
    bit     exp_er [MAXC];

    // Frame model state, advanced on input samples.
    bit     in_frame = 1'b0;
    int     nxt = 0;
    int     best_i = 0;
    longint best_p = 0;
    int     blk = -1;
    int     last_cyc = 0;

    int     fr_re [NB];
    int     fr_im [NB];

    task automatic cmp(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic model_in(input int c, input bit v, input int idx,
                            input int re, input int im);
        longint p;
        p = longint'(re) * re + longint'(im) * im;
        if (c + 4 >= MAXC) return;
        if (v) begin
            exp_pv[c+3] = 1'b1;
            exp_pi[c+3] = idx;
            exp_pp[c+3] = p;
        end
        if (!in_frame) begin
            if (v && idx == 0 && c != blk) begin
                in_frame = 1'b1;
                nxt      = 1;
                best_i   = 0;
`ifdef FFT_PEAK_SKIP_DC_EN
                best_p   = 0;
`else
                best_p   = p;
`endif
            end
        end else if (!v || idx != nxt) begin
            exp_er[c+4] = 1'b1;
            in_frame    = 1'b0;
        end else begin
            if (p > best_p) begin
                best_p = p;
                best_i = idx;
            end
            if (idx == NB - 1) begin
                exp_pk[c+4] = 1'b1;
                exp_ki[c+4] = best_i;
                exp_kp[c+4] = best_p;
                in_frame    = 1'b0;
                blk         = c + 1;
            end else begin
                nxt++;
            end
        end
    endtask

    task automatic drive(input bit v, input int idx, input int re, input int im);
        @(posedge clk);
        #1;
        in_valid = v;
        in_idx   = N'(idx);
        in_re    = W'(re);
        in_im    = W'(im);
        if (!rst_active) model_in(cyc, v, idx, re, im);
        last_cyc = cyc;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 0);
    endtask

    task automatic clear_frame();
        for (int k = 0; k < NB; k++) begin
            fr_re[k] = 0;
            fr_im[k] = 0;
        end
    endtask

    task automatic send_frame(input int first, input int last);
        for (int k = first; k <= last; k++) drive(1'b1, k, fr_re[k], fr_im[k]);
    endtask

    // Idles the input until peak_valid (sel=0) or frame_err (sel=1) shows.
    task automatic wait_sig(input int sel, output int at, output bit other);
        at    = -1;
        other = 1'b0;
        for (int k = 0; k < 12; k++) begin
            drive(1'b0, 0, 0, 0);
            #2;
            if (sel == 0 ? peak_valid : frame_err) begin
                at = cyc;
                return;
            end
            if (sel == 0 ? frame_err : peak_valid) other = 1'b1;
        end
        n_tests++;
        n_fail++;
        $display("FAIL wait_%s timeout", sel == 0 ? "peak" : "err");
    endtask

    task automatic watch_pwr(input int idx, input longint exp);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (pwr_valid && int'(pwr_idx) == idx) begin
                cmp("pwr_lit", pwr_out, exp);
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL pwr_lit timeout idx=%0d", idx);
    endtask

    task automatic check_zero(input string nm);
        cmp({nm, "_pv"}, pwr_valid, 0);
        cmp({nm, "_pwr"}, pwr_out, 0);
        cmp({nm, "_pkv"}, peak_valid, 0);
        cmp({nm, "_pki"}, peak_idx, 0);
        cmp({nm, "_pkp"}, peak_pwr, 0);
        cmp({nm, "_err"}, frame_err, 0);
    endtask

    int     held_i = 0;
    longint held_p = 0;

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst_active || cyc >= MAXC) begin
            held_i = 0;
            held_p = 0;
        end else begin
            if (exp_pk[cyc]) begin
                held_i = exp_ki[cyc];
                held_p = exp_kp[cyc];
            end
            cmp("pwr_valid", pwr_valid, exp_pv[cyc]);
            if (exp_pv[cyc]) begin
                cmp("pwr_idx", pwr_idx, exp_pi[cyc]);
                cmp("pwr_out", pwr_out, exp_pp[cyc]);
            end
            cmp("peak_valid", peak_valid, exp_pk[cyc]);
            cmp("frame_err", frame_err, exp_er[cyc]);
            cmp("peak_idx", peak_idx, held_i);
            cmp("peak_pwr", peak_pwr, held_p);
        end
    end

    int at;
    int t_last;
    bit other;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(posedge clk);
        #1;
        areset     = 1'b1;
        rst_active = 1'b0;
        idle(2);

        // 1: single tone at bin 5
        clear_frame();
        fr_re[5] = 1000;
        fork
            send_frame(0, NB - 1);
            watch_pwr(5, 64'd1000000);
        join
        t_last = last_cyc;
        wait_sig(0, at, other);
        cmp("t1_latency", at - t_last, 4);
        cmp("t1_idx", peak_idx, 5);
        cmp("t1_pwr", peak_pwr, 64'd1000000);
        idle(2);

        // 2: stale idx 63 ahead of the frame
        clear_frame();
        for (int k = 0; k < NB; k++) fr_re[k] = k * 10;
        fr_re[20] = 5000;
        drive(1'b1, NB - 1, 30000, 0);
        send_frame(0, NB - 1);
        wait_sig(0, at, other);
        cmp("t2_idx", peak_idx, 20);
        cmp("t2_pwr", peak_pwr, 64'd25000000);
        idle(2);

        // 3: tie keeps lower bin
        clear_frame();
        for (int k = 0; k < NB; k++) begin
            fr_re[k] = 1;
            fr_im[k] = 1;
        end
        fr_re[7]  = -300;
        fr_im[7]  = 400;
        fr_re[40] = -300;
        fr_im[40] = 400;
        send_frame(0, NB - 1);
        wait_sig(0, at, other);
        cmp("t3_idx", peak_idx, 7);
        cmp("t3_pwr", peak_pwr, 64'd250000);
        idle(2);

        // 4: most negative inputs
        clear_frame();
        fr_re[1] = -32768;
        fr_im[1] = -32768;
        fork
            send_frame(0, NB - 1);
            watch_pwr(1, 64'h8000_0000);
        join
        wait_sig(0, at, other);
        cmp("t4_idx", peak_idx, 1);
        cmp("t4_pwr", peak_pwr, 64'h8000_0000);
        idle(2);

        // 5a: aborted frame leaves peak untouched
        clear_frame();
        fr_re[5] = 1000;
        send_frame(0, 30);
        wait_sig(1, at, other);
        cmp("t5_no_peak", other, 0);
        cmp("t5_hold_idx", peak_idx, 1);
        cmp("t5_hold_pwr", peak_pwr, 64'h8000_0000);
        idle(2);
        send_frame(0, NB - 1);
        wait_sig(0, at, other);
        cmp("t5_idx", peak_idx, 5);
        cmp("t5_pwr", peak_pwr, 64'd1000000);
        idle(2);

        // 5b: reset mid-frame
        send_frame(0, 40);
        @(posedge clk);
        #1;
        areset     = 1'b0;
        rst_active = 1'b1;
        in_valid   = 1'b0;
        for (int k = cyc; k < MAXC; k++) begin
            exp_pv[k] = 1'b0;
            exp_pk[k] = 1'b0;
            exp_er[k] = 1'b0;
        end
        in_frame = 1'b0;
        blk      = -1;
        #1;
        check_zero("t5_rst");
        idle(2);
        @(posedge clk);
        #1;
        areset     = 1'b1;
        rst_active = 1'b0;
        idle(2);

        // 6: strong DC bin
        clear_frame();
        fr_re[0] = 5000;
        fr_re[9] = 10;
        send_frame(0, NB - 1);
        wait_sig(0, at, other);
`ifdef FFT_PEAK_SKIP_DC_EN
        cmp("t6_idx", peak_idx, 9);
        cmp("t6_pwr", peak_pwr, 64'd100);
`else
        cmp("t6_idx", peak_idx, 0);
        cmp("t6_pwr", peak_pwr, 64'd25000000);
`endif
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
